read_fsm: RTL
=============

Name: read_fsm

Overview:
- Read-side counterpart to the keypad write FSM.
- When the write FSM pulses result_ready, this block reads back the two stored operands from the calculator register file. Operand A comes from the user-selected register; operand B comes from the entry register.
- Each packed two-digit BCD value is converted to binary, and the operand pair plus opcode is presented to the ALU over a valid/ready handshake.
- Sits between the register file read port and the ALU.

Parameters:
- REG_AW, 2, register-file address width.
- ENTRY_ADDR, 3, register index holding the second (most recently typed) number.
- OUT_W, 7, binary operand width; must be >= 7 so that 99 fits.

Ports:
- clk  input  1  system clock, rising-edge.
- rst  input  1  synchronous active-high reset.
- result_ready  input  1  one-cycle pulse from the write FSM: operands are stored, start a read.
- reg_sel  input  REG_AW  register index of operand A; sampled with result_ready.
- op_sel  input  2  operator code; sampled with result_ready.
- rd_en  output  1  register-file read strobe.
- rd_addr  output  REG_AW  register-file read address.
- rd_data  input  8  packed BCD, [7:4] tens and [3:0] ones; valid the cycle after rd_en.
- op_a  output  OUT_W  binary operand A.
- op_b  output  OUT_W  binary operand B.
- op_code  output  2  latched op_sel.
- op_valid  output  1  operand pair valid.
- alu_ready  input  1  ALU accepts the pair.
- bcd_err  output  1  a nibble > 9 was found in either operand; qualified by op_valid.
- busy  output  1  high in any state other than IDLE.
- overrun  output  1  sticky; set when result_ready arrives while busy.

Behaviour:
- Clock and reset: one clock, clk. Reset rst is synchronous and active-high.
- Reset values:
  - All outputs are 0 and the state is IDLE.
  - A reset asserted mid-operation aborts the read. On the next edge all outputs are 0 and the state is IDLE, with no partial op_valid.
- Outputs are registered, except rd_en and rd_addr, which are decoded from state.

States:
- IDLE:
  - rd_en = 0.
  - When result_ready = 1: latch reg_sel and op_sel (op_code updates here), then go to RD_A.
  - Otherwise stay in IDLE.
- RD_A:
  - rd_en = 1, rd_addr = latched reg_sel.
  - Unconditionally go to RD_B.
- RD_B:
  - rd_en = 1, rd_addr = ENTRY_ADDR.
  - rd_data currently holds A. On the edge, capture conv(A) into op_a and record A's error bit.
  - Go to CAP_B.
- CAP_B:
  - rd_en = 0.
  - rd_data holds B. On the edge, capture conv(B) into op_b.
  - Set bcd_err to errA OR errB, set op_valid = 1, go to VALID.
- VALID:
  - op_valid = 1; op_a, op_b, op_code and bcd_err are held stable.
  - When alu_ready = 1 on an edge: clear op_valid and bcd_err, go to IDLE.
  - alu_ready is ignored in every other state.

Latency:
- If result_ready is sampled at edge k, then rd_en is high during cycles k..k+2 (RD_A and RD_B).
- op_valid rises after edge k+3.
- Minimum turnaround from one result_ready to the next accepted result_ready is 4 edges plus the handshake.

Conversion, conv(x):
- conv(x) = x[7:4]*10 + x[3:0], zero-extended to OUT_W.
- If either nibble is > 9, the value is 0 and the error bit is set for that operand.
- rd_addr = ENTRY_ADDR = reg_sel is legal; the same register is read twice.

Boundaries:
- result_ready in a non-IDLE state: ignored (no restart, no change to latched inputs) and sets overrun. overrun clears only on rst.
- result_ready and alu_ready in the same edge while in VALID: handshake completes to IDLE; result_ready is treated as an overrun and is not queued.
- result_ready held high for multiple cycles: the first cycle starts the read; the following high cycles land in a non-IDLE state and set overrun.

Test Plan:
- Bench register-file model with 1-cycle read latency: reg1 = 8'h42, reg3 = 8'h17. Pulse result_ready with reg_sel = 1, op_sel = 2'b10 -> rd_addr is 1 then 3; op_a = 42, op_b = 17, op_code = 2'b10, bcd_err = 0; op_valid rises 3 edges after the pulse.
- Same setup with alu_ready held low for 5 cycles, then high for 1 -> op_valid and operands stay stable for all 5 cycles; op_valid = 0 and busy = 0 after the accepting edge.
- reg2 = 8'h9A, reg_sel = 2 -> op_a = 0, op_b = 17, bcd_err = 1 with op_valid. Then reg2 = 8'h99 -> op_a = 99, bcd_err = 0.
- Second result_ready pulse while in VALID with alu_ready = 0 -> overrun = 1 and operands unchanged. After acceptance overrun is still 1; rst clears it.
- rst asserted during RD_B -> on the next edge rd_en = 0, op_valid = 0, busy = 0, op_a = 0. A fresh pulse afterwards completes normally.
- reg_sel = 3 (equal to ENTRY_ADDR), reg3 = 8'h05 -> op_a = 5, op_b = 5; rd_addr is 3 on both read cycles.

Source files
------------

// File: rtl/read_fsm.sv
// -----------------------------------------------------------------------------
// read_fsm
//
// Read side of the keypad calculator. On a result_ready pulse from the write
// FSM it reads operand A from the user-selected register and operand B from
// the entry register. It converts each packed two-digit BCD value to binary
// and offers the pair plus opcode to the ALU with a valid/ready handshake.
//
// Ports
//   clk          system clock, rising edge
//   rst          synchronous active-high reset
//   result_ready one-cycle start pulse; reg_sel/op_sel are sampled with it
//   reg_sel      register index of operand A
//   op_sel       operator code
//   rd_en        register-file read strobe (decoded from state)
//   rd_addr      register-file read address (decoded from state)
//   rd_data      packed BCD read data, valid the cycle after rd_en
//   op_a, op_b   binary operands
//   op_code      latched op_sel
//   op_valid     operand pair valid
//   alu_ready    ALU accepts the pair
//   bcd_err      a nibble > 9 was seen in either operand (qualified by op_valid)
//   busy         any state other than IDLE
//   overrun      sticky: result_ready arrived while busy; cleared only by rst
// -----------------------------------------------------------------------------
module read_fsm #(
  parameter int REG_AW     = 2,
  parameter int ENTRY_ADDR = 3,
  parameter int OUT_W      = 7
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              result_ready,
  input  logic [REG_AW-1:0] reg_sel,
  input  logic [1:0]        op_sel,
  output logic              rd_en,
  output logic [REG_AW-1:0] rd_addr,
  input  logic [7:0]        rd_data,
  output logic [OUT_W-1:0]  op_a,
  output logic [OUT_W-1:0]  op_b,
  output logic [1:0]        op_code,
  output logic              op_valid,
  input  logic              alu_ready,
  output logic              bcd_err,
  output logic              busy,
  output logic              overrun
);

  // 99 is the largest converted value and needs 7 bits.
  if (OUT_W < 7) begin : g_width_check
    $error("read_fsm: OUT_W must be at least 7");
  end

  localparam logic [REG_AW-1:0] ENTRY_IDX = REG_AW'(ENTRY_ADDR);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    RD_A  = 3'd1,
    RD_B  = 3'd2,
    CAP_B = 3'd3,
    VALID = 3'd4
  } state_t;

  state_t            state_reg, state_next;
  logic [REG_AW-1:0] sel_reg, sel_next;
  logic [1:0]        op_code_reg, op_code_next;
  logic [OUT_W-1:0]  op_a_reg, op_a_next;
  logic [OUT_W-1:0]  op_b_reg, op_b_next;
  logic              err_a_reg, err_a_next;
  logic              bcd_err_reg, bcd_err_next;
  logic              op_valid_reg, op_valid_next;
  logic              busy_reg, busy_next;
  logic              overrun_reg, overrun_next;

  // ---------------------------------------------------------------------------
  // BCD to binary conversion of whatever is on rd_data this cycle.
  // ---------------------------------------------------------------------------
  logic [1:0]       nib_bad;
  logic             conv_err;
  logic [6:0]       conv_bin;
  logic [OUT_W-1:0] conv_val;

  for (genvar gi = 0; gi < 2; gi++) begin : g_nib_check
    assign nib_bad[gi] = (rd_data[gi*4 +: 4] > 4'd9);
  end

  assign conv_err = |nib_bad;
  // tens*10 computed as tens*8 + tens*2; max 99 when both nibbles are legal.
  assign conv_bin = {rd_data[7:4], 3'b000} + {2'b00, rd_data[7:4], 1'b0}
                  + {3'b000, rd_data[3:0]};
  // An illegal operand is forced to zero rather than passing a garbage value.
  assign conv_val = conv_err ? '0 : OUT_W'(conv_bin);

  // ---------------------------------------------------------------------------
  // State and datapath registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg    <= IDLE;
      sel_reg      <= '0;
      op_code_reg  <= '0;
      op_a_reg     <= '0;
      op_b_reg     <= '0;
      err_a_reg    <= 1'b0;
      bcd_err_reg  <= 1'b0;
      op_valid_reg <= 1'b0;
      busy_reg     <= 1'b0;
      overrun_reg  <= 1'b0;
    end else begin
      state_reg    <= state_next;
      sel_reg      <= sel_next;
      op_code_reg  <= op_code_next;
      op_a_reg     <= op_a_next;
      op_b_reg     <= op_b_next;
      err_a_reg    <= err_a_next;
      bcd_err_reg  <= bcd_err_next;
      op_valid_reg <= op_valid_next;
      busy_reg     <= busy_next;
      overrun_reg  <= overrun_next;
    end
  end

  // ---------------------------------------------------------------------------
  // Next-state and next-output logic
  // ---------------------------------------------------------------------------
  always_comb begin
    state_next    = state_reg;
    sel_next      = sel_reg;
    op_code_next  = op_code_reg;
    op_a_next     = op_a_reg;
    op_b_next     = op_b_reg;
    err_a_next    = err_a_reg;
    bcd_err_next  = bcd_err_reg;
    op_valid_next = op_valid_reg;
    // A start request outside IDLE is dropped, never queued, and flagged.
    // This includes the edge on which VALID hands off to the ALU.
    overrun_next  = overrun_reg | (result_ready && (state_reg != IDLE));

    unique case (state_reg)
      IDLE: begin
        if (result_ready) begin
          sel_next     = reg_sel;
          op_code_next = op_sel;
          state_next   = RD_A;
        end
      end
      RD_A: begin
        state_next = RD_B;
      end
      RD_B: begin
        // rd_data carries operand A (read issued in RD_A).
        op_a_next  = conv_val;
        err_a_next = conv_err;
        state_next = CAP_B;
      end
      CAP_B: begin
        // rd_data carries operand B (read issued in RD_B).
        op_b_next     = conv_val;
        bcd_err_next  = err_a_reg | conv_err;
        op_valid_next = 1'b1;
        state_next    = VALID;
      end
      VALID: begin
        if (alu_ready) begin
          op_valid_next = 1'b0;
          bcd_err_next  = 1'b0;
          state_next    = IDLE;
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase

    busy_next = (state_next != IDLE);
  end

  // ---------------------------------------------------------------------------
  // Read port decode: A address in RD_A, entry register in RD_B.
  // ---------------------------------------------------------------------------
  always_comb begin
    rd_en   = 1'b0;
    rd_addr = '0;
    if (state_reg == RD_A) begin
      rd_en   = 1'b1;
      rd_addr = sel_reg;
    end else if (state_reg == RD_B) begin
      rd_en   = 1'b1;
      rd_addr = ENTRY_IDX;
    end
  end

  assign op_a     = op_a_reg;
  assign op_b     = op_b_reg;
  assign op_code  = op_code_reg;
  assign op_valid = op_valid_reg;
  assign bcd_err  = bcd_err_reg;
  assign busy     = busy_reg;
  assign overrun  = overrun_reg;

endmodule
